lsu_axi_master: RTL

//  Memory-side stage directly downstream of the LSU: takes one load/store request per transaction
//  (valid/ready), issues it as a single-beat AXI4-Lite read or write on the 64-bit data bus,
//  and returns the 8-byte-aligned read data or the write completion to the LSU.
//  The LSU does the byte shifting, strobe generation and sign extension.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_wd_timer.sv | 25 ++
 rtl/lsu_axi_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI response codes and the LSU-to-AXI sequencer state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/axi_wd_timer.sv
// Bus watchdog: counts enabled cycles since the last clear and flags expiry at TIMEOUT_CYC.
module axi_wd_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && !expired_c)  cnt <= cnt + CNT_W'(1);
  end

  // Fires during the TIMEOUT_CYC-th enabled cycle so the FSM leaves on that edge.
  assign expired_c = en && (cnt >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lsu_axi_master.sv
// Single-beat AXI4-Lite master behind the LSU: aligned 64-bit loads/stores.
// Optional bus watchdog enabled by defining LSU_AXI_TIMEOUT_EN.
module lsu_axi_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp
);

  localparam int unsigned STRB_W = DATA_W / 8;

  lsu_state_e          state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                accept;
  logic                bus_busy;
  logic                timeout_c;
  logic                awv_nx, wv_nx, arv_nx, rr_nx, br_nx, rv_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                err_nx;

  assign bus_busy = (state == RD_ADDR) || (state == RD_DATA) ||
                    (state == WR_REQ)  || (state == WR_RESP);

`ifdef LSU_AXI_TIMEOUT_EN
  axi_wd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (bus_busy),
    .expired_c (timeout_c)
  );
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_c = 1'b0;
`endif

  // Low response bits and the in-word byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{m_bresp[0], m_rresp[0], req_addr[2:0], bus_busy};

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_bready   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      req_ready  <= (state_nx == IDLE);
      m_awvalid  <= awv_nx;
      m_wvalid   <= wv_nx;
      m_arvalid  <= arv_nx;
      m_rready   <= rr_nx;
      m_bready   <= br_nx;
      resp_valid <= rv_nx;
      resp_rdata <= rdata_nx;
      resp_err   <= err_nx;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Next state plus the registered channel handshake signals it implies.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    awv_nx   = 1'b0;
    wv_nx    = 1'b0;
    arv_nx   = 1'b0;
    rr_nx    = 1'b0;
    br_nx    = 1'b0;
    rv_nx    = 1'b0;
    rdata_nx = resp_rdata;
    err_nx   = resp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          rdata_nx = '0;
          err_nx   = 1'b0;
          if (!req_write) begin
            state_nx = RD_ADDR;
            arv_nx   = 1'b1;
          end else if (req_wstrb == '0) begin
            state_nx = RESP;
            rv_nx    = 1'b1;
          end else begin
            state_nx = WR_REQ;
            awv_nx   = 1'b1;
            wv_nx    = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          state_nx = RD_DATA;
          rr_nx    = 1'b1;
        end else begin
          arv_nx = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          state_nx = RESP;
          rv_nx    = 1'b1;
          rdata_nx = m_rdata;
          err_nx   = m_rresp[1];
        end else begin
          rr_nx = 1'b1;
        end
      end
      WR_REQ: begin
        awv_nx = m_awvalid && !m_awready;
        wv_nx  = m_wvalid && !m_wready;
        if (!awv_nx && !wv_nx) begin
          state_nx = WR_RESP;
          br_nx    = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          state_nx = RESP;
          rv_nx    = 1'b1;
          err_nx   = m_bresp[1];
        end else begin
          br_nx = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
        else            rv_nx    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // Watchdog abandons the bus transaction and reports an error.
    if (timeout_c) begin
      state_nx = RESP;
      awv_nx   = 1'b0;
      wv_nx    = 1'b0;
      arv_nx   = 1'b0;
      rr_nx    = 1'b0;
      br_nx    = 1'b0;
      rv_nx    = 1'b1;
      rdata_nx = '0;
      err_nx   = 1'b1;
    end
  end

endmodule
